clock_mode_ctrl: RTL

Mode controller between the button debouncer and the clock/alarm datapath. Consumes single-cycle button command pulses (`common_pkg::con_op_t`), runs the user-interface state machine (display / set time / set alarm), tracks the edit cursor and alarm-enable state, and issues registered commands (`common_pkg::clock_op_t`) to the timekeeping block. An optional inactivity timeout returns the UI to display mode.

---
 rtl/clock_mode_ctrl.sv | 81 ++++++++
 1 files changed

// File: rtl/clock_mode_ctrl.sv
// clock_mode_ctrl: UI mode FSM turning button pulses into registered clock datapath commands.
// Optional inactivity timeout back to display mode is enabled by defining INACTIVITY_TIMEOUT_EN.
module clock_mode_ctrl #(
  parameter int CURSOR_FIELDS = 4,
  parameter int TIMEOUT_TICKS = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] btn_i,
  input  logic       tick_1hz_i,
  output logic [5:0] clock_op_o,
  output logic [1:0] mode_o,
  output logic [1:0] cursor_o,
  output logic       alarm_en_o
);
  typedef enum logic [1:0] {S_DISPLAY = 2'd0, S_SET_TIME = 2'd1, S_SET_ALARM = 2'd2} state_t;
  state_t state, nxt, st_n;
  logic [5:0] pick;
  logic [1:0] cur_n;
  logic al_n, tog, lft, up, acc, set, expire;
  assign set = state != S_DISPLAY;
  assign mode_o = state;
  always_comb begin
    pick = '0;
    for (int i = 0; i < 6; i++) if (btn_i[i]) pick = 6'(1) << i;
    nxt = state;
    cur_n = cursor_o;
    al_n = alarm_en_o;
    tog = 1'b0;
    lft = 1'b0;
    up = 1'b0;
    if (!set) begin
      if (pick[4]) begin nxt = S_SET_TIME; cur_n = '0; end
      if (pick[3]) begin nxt = S_SET_ALARM; cur_n = '0; end
      if (pick[2]) begin al_n = ~alarm_en_o; tog = 1'b1; end
    end else begin
      if (pick[5]) nxt = S_DISPLAY;
      if (pick[4]) begin
        nxt = (state == S_SET_TIME) ? S_DISPLAY : S_SET_TIME;
        cur_n = (state == S_SET_TIME) ? cursor_o : 2'd0;
      end
      if (pick[3]) begin
        nxt = (state == S_SET_ALARM) ? S_DISPLAY : S_SET_ALARM;
        cur_n = (state == S_SET_ALARM) ? cursor_o : 2'd0;
      end
      if (pick[1]) begin
        cur_n = (cursor_o == 2'(CURSOR_FIELDS - 1)) ? 2'd0 : cursor_o + 2'd1;
        lft = 1'b1;
      end
      up = pick[0];
    end
    acc = set ? (|pick[5:3] || |pick[1:0]) : |pick[4:2];
    st_n = expire ? S_DISPLAY : nxt;
  end
`ifdef INACTIVITY_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_TICKS + 1);
  logic [CW-1:0] cnt;
  // A button in the same cycle as expiry wins; the timeout only fires on an idle cycle.
  assign expire = set && !acc && cnt == CW'(TIMEOUT_TICKS);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (acc || st_n == S_DISPLAY) cnt <= '0;
    else if (tick_1hz_i && cnt != CW'(TIMEOUT_TICKS)) cnt <= cnt + 1'b1;
`else
  logic unused_tick;
  assign unused_tick = tick_1hz_i;
  assign expire = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_DISPLAY;
      cursor_o <= '0;
      alarm_en_o <= 1'b0;
      clock_op_o <= 6'b100000;
    end else begin
      state <= st_n;
      cursor_o <= cur_n;
      alarm_en_o <= al_n;
      clock_op_o <= {st_n == S_DISPLAY, st_n == S_SET_TIME, st_n == S_SET_ALARM, tog, lft, up};
    end
endmodule
